// File: rtl/mem_sched_pkg.sv
// Shared definitions for the memory scheduler: size codes, requester owners,
// FSM states and the byte-count / load-extension helpers.
package mem_sched_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    OWN_IF = 2'd0,
    OWN_LD = 2'd1,
    OWN_ST = 2'd2
  } owner_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  // Size code 3 falls through to a full word.
  function automatic logic [2:0] beats_of(input logic [1:0] sz);
    logic [2:0] n;
    case (sz)
      SZ_B:    n = 3'd1;
      SZ_H:    n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  function automatic logic [31:0] extend_load(input logic [31:0] raw,
                                              input logic [1:0]  sz,
                                              input logic        sgn);
    logic [31:0] v;
    case (sz)
      SZ_B:    v = {{24{sgn & raw[7]}}, raw[7:0]};
      SZ_H:    v = {{16{sgn & raw[15]}}, raw[15:0]};
      default: v = raw;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mem_byte_seq.sv
// Byte-beat sequencer: cycle counter, RAM address/write-lane drive and
// little-endian read assembly with sign/zero extension.
module mem_byte_seq
  import mem_sched_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [1:0]        i_size,
  input  logic              i_signed,
  input  logic [31:0]       i_wdata,
  input  logic              i_step,
  input  logic              i_clr,
  input  logic              i_cap_en,
  input  logic [7:0]        i_rdata,
  output logic [2:0]        o_cyc,
  output logic [2:0]        o_nbeat,
  output logic              o_drv_v,
  output logic [ADDR_W-1:0] o_addr,
  output logic [7:0]        o_wbyte,
  output logic [31:0]       o_rd_word
);

  logic [ADDR_W-1:0] r_base;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [31:0]       r_wdata;
  logic [2:0]        r_cyc;
  logic              r_drv_v;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_wbyte;
  logic              r_prv_v;
  logic [1:0]        r_prv_idx;
  logic [3:0][7:0]   r_lane;

  logic [2:0]        w_nbeat;
  logic [2:0]        w_nxt_idx;
  logic              w_nxt_v;
  logic [ADDR_W-1:0] w_nxt_addr;
  logic [7:0]        w_nxt_byte;
  logic [31:0]       w_raw;

  assign w_nbeat    = beats_of(r_size);
  assign w_nxt_idx  = r_cyc + 3'd1;
  assign w_nxt_v    = (w_nxt_idx < w_nbeat);
  assign w_nxt_addr = r_base + ADDR_W'(w_nxt_idx);

  // Write lane for the next beat.
  always_comb begin
    w_nxt_byte = 8'd0;
    case (w_nxt_idx[1:0])
      2'd0:    w_nxt_byte = r_wdata[7:0];
      2'd1:    w_nxt_byte = r_wdata[15:8];
      2'd2:    w_nxt_byte = r_wdata[23:16];
      default: w_nxt_byte = r_wdata[31:24];
    endcase
  end

  // Merge the byte arriving this cycle so the ack edge sees the complete word.
  always_comb begin
    w_raw = 32'd0;
    for (int j = 0; j < 4; j++) begin
      if (r_prv_v && (r_prv_idx == 2'(j))) begin
        w_raw[8*j +: 8] = i_rdata;
      end else begin
        w_raw[8*j +: 8] = r_lane[j];
      end
    end
  end

  // Beat state: latch on start, advance on step, and tag each returning RAM
  // byte with the index driven one cycle earlier so stalls never misplace it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base    <= '0;
      r_size    <= 2'd0;
      r_signed  <= 1'b0;
      r_wdata   <= 32'd0;
      r_cyc     <= 3'd0;
      r_drv_v   <= 1'b0;
      r_addr    <= '0;
      r_wbyte   <= 8'd0;
      r_prv_v   <= 1'b0;
      r_prv_idx <= 2'd0;
      r_lane    <= '0;
    end else if (i_start) begin
      r_base    <= i_base;
      r_size    <= i_size;
      r_signed  <= i_signed;
      r_wdata   <= i_wdata;
      r_cyc     <= 3'd0;
      r_drv_v   <= 1'b1;
      r_addr    <= i_base;
      r_wbyte   <= i_wdata[7:0];
      r_prv_v   <= 1'b0;
      r_prv_idx <= 2'd0;
      r_lane    <= '0;
    end else if (i_clr) begin
      r_drv_v <= 1'b0;
      r_addr  <= '0;
      r_wbyte <= 8'd0;
      r_prv_v <= 1'b0;
    end else begin
      if (i_step) begin
        r_cyc   <= w_nxt_idx;
        r_drv_v <= w_nxt_v;
        r_addr  <= w_nxt_v ? w_nxt_addr : '0;
        r_wbyte <= w_nxt_v ? w_nxt_byte : 8'd0;
      end
      if (i_cap_en) begin
        if (r_prv_v) begin
          r_lane[r_prv_idx] <= i_rdata;
        end
        r_prv_v   <= r_drv_v;
        r_prv_idx <= r_cyc[1:0];
      end
    end
  end

  assign o_cyc     = r_cyc;
  assign o_nbeat   = w_nbeat;
  assign o_drv_v   = r_drv_v;
  assign o_addr    = r_addr;
  assign o_wbyte   = r_wbyte;
  assign o_rd_word = extend_load(w_raw, r_size, r_signed);

endmodule

// File: rtl/mem_sched.sv
// mem_sched: owns the byte-wide RAM port for fetch, load and store commit.
// Fixed priority ST > LD > IF with an IF starvation guard and read abort on flush.
module mem_sched #(
  parameter int ADDR_W     = 32,
  parameter int STARVE_LIM = 8
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              flush_in,
  input  logic              if_req_in,
  input  logic [ADDR_W-1:0] if_addr_in,
  output logic              if_ack_out,
  output logic [31:0]       if_data_out,
  input  logic              ld_req_in,
  input  logic [ADDR_W-1:0] ld_addr_in,
  input  logic [1:0]        ld_size_in,
  input  logic              ld_signed_in,
  output logic              ld_ack_out,
  output logic [31:0]       ld_data_out,
  input  logic              st_req_in,
  input  logic [ADDR_W-1:0] st_addr_in,
  input  logic [1:0]        st_size_in,
  input  logic [31:0]       st_data_in,
  output logic              st_ack_out,
  input  logic [7:0]        ram_rdata_in,
  output logic [ADDR_W-1:0] ram_addr_out,
  output logic [7:0]        ram_wdata_out,
  output logic              ram_rw_out,
  output logic              busy_out
);

  import mem_sched_pkg::*;

  localparam int              SC_W   = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SC_W-1:0] SC_LIM = SC_W'(STARVE_LIM);

  state_e            r_state, w_state_nxt;
  owner_e            r_owner, w_owner_nxt;
  logic [SC_W-1:0]   r_starve_cnt, w_starve_nxt;
  logic              r_if_ack, r_ld_ack, r_st_ack;
  logic [31:0]       r_if_data, r_ld_data;

  logic              w_start, w_step, w_clr, w_cap_en;
  logic              w_done_rd, w_done_wr, w_exit_done;
  logic              w_if_force;
  logic [ADDR_W-1:0] w_g_addr;
  logic [1:0]        w_g_size;
  logic              w_g_signed;
  logic [31:0]       w_g_wdata;
  logic [2:0]        w_cyc, w_nbeat;
  logic              w_drv_v;
  logic [ADDR_W-1:0] w_addr;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_rd_word;

  assign w_if_force = if_req_in && !flush_in && (r_starve_cnt == SC_LIM);
  assign w_cap_en   = (r_state == S_RD) && !w_clr;

  // Arbitration, beat control and next-state decode.
  always_comb begin
    w_state_nxt  = r_state;
    w_owner_nxt  = r_owner;
    w_starve_nxt = r_starve_cnt;
    w_start      = 1'b0;
    w_step       = 1'b0;
    w_clr        = 1'b0;
    w_done_rd    = 1'b0;
    w_done_wr    = 1'b0;
    w_exit_done  = 1'b0;
    w_g_addr     = '0;
    w_g_size     = SZ_W;
    w_g_signed   = 1'b0;
    w_g_wdata    = 32'd0;
    case (r_state)
      S_IDLE: begin
        if (rdy_in) begin
          if (w_if_force) begin
            w_start     = 1'b1;
            w_owner_nxt = OWN_IF;
            w_g_addr    = if_addr_in;
            w_state_nxt = S_RD;
          end else if (st_req_in) begin
            w_start     = 1'b1;
            w_owner_nxt = OWN_ST;
            w_g_addr    = st_addr_in;
            w_g_size    = st_size_in;
            w_g_wdata   = st_data_in;
            w_state_nxt = S_WR;
          end else if (ld_req_in && !flush_in) begin
            w_start     = 1'b1;
            w_owner_nxt = OWN_LD;
            w_g_addr    = ld_addr_in;
            w_g_size    = ld_size_in;
            w_g_signed  = ld_signed_in;
            w_state_nxt = S_RD;
          end else if (if_req_in && !flush_in) begin
            w_start     = 1'b1;
            w_owner_nxt = OWN_IF;
            w_g_addr    = if_addr_in;
            w_state_nxt = S_RD;
          end else begin
            w_state_nxt = S_IDLE;
          end
          // Starvation window tracks only ST/LD wins over a waiting fetch.
          if (w_start && (w_owner_nxt == OWN_IF)) begin
            w_starve_nxt = '0;
          end else if (!if_req_in) begin
            w_starve_nxt = '0;
          end else if (w_start && (r_starve_cnt != SC_LIM)) begin
            w_starve_nxt = r_starve_cnt + SC_W'(1);
          end else begin
            w_starve_nxt = r_starve_cnt;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        if (rdy_in) begin
          if (flush_in) begin
            w_clr       = 1'b1;
            w_state_nxt = S_IDLE;
          end else if (w_cyc == w_nbeat) begin
            w_done_rd   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_step = 1'b1;
          end
        end else begin
          w_step = 1'b0;
        end
      end
      S_WR: begin
        if (rdy_in) begin
          w_step = 1'b1;
          if (w_cyc == (w_nbeat - 3'd1)) begin
            w_done_wr   = 1'b1;
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_WR;
          end
        end else begin
          w_step = 1'b0;
        end
      end
      S_DONE: begin
        if (rdy_in) begin
          w_exit_done = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_exit_done = 1'b0;
        end
      end
      default: begin
        w_clr       = 1'b1;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state, current owner and starvation counter.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state      <= S_IDLE;
      r_owner      <= OWN_IF;
      r_starve_cnt <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  // Completion pulses and returned data; pulses clear as DONE is left.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_if_ack  <= 1'b0;
      r_ld_ack  <= 1'b0;
      r_st_ack  <= 1'b0;
      r_if_data <= 32'd0;
      r_ld_data <= 32'd0;
    end else if (w_done_rd) begin
      if (r_owner == OWN_IF) begin
        r_if_ack  <= 1'b1;
        r_if_data <= w_rd_word;
      end else begin
        r_ld_ack  <= 1'b1;
        r_ld_data <= w_rd_word;
      end
    end else if (w_done_wr) begin
      r_st_ack <= 1'b1;
    end else if (w_exit_done) begin
      r_if_ack <= 1'b0;
      r_ld_ack <= 1'b0;
      r_st_ack <= 1'b0;
    end
  end

  mem_byte_seq #(
    .ADDR_W (ADDR_W)
  ) u_seq (
    .i_clk     (clk_in),
    .i_rst_n   (rst_in),
    .i_start   (w_start),
    .i_base    (w_g_addr),
    .i_size    (w_g_size),
    .i_signed  (w_g_signed),
    .i_wdata   (w_g_wdata),
    .i_step    (w_step),
    .i_clr     (w_clr),
    .i_cap_en  (w_cap_en),
    .i_rdata   (ram_rdata_in),
    .o_cyc     (w_cyc),
    .o_nbeat   (w_nbeat),
    .o_drv_v   (w_drv_v),
    .o_addr    (w_addr),
    .o_wbyte   (w_wbyte),
    .o_rd_word (w_rd_word)
  );

  // A stalled write beat must not strobe the RAM, so rdy_in gates the strobe directly.
  assign ram_rw_out    = ((r_state == S_WR) && w_drv_v && rdy_in) ? RW_WRITE : RW_READ;
  assign ram_addr_out  = w_addr;
  assign ram_wdata_out = w_wbyte;
  assign busy_out      = (r_state != S_IDLE);
  assign if_ack_out    = r_if_ack;
  assign ld_ack_out    = r_ld_ack;
  assign st_ack_out    = r_st_ack;
  assign if_data_out   = r_if_data;
  assign ld_data_out   = r_ld_data;

endmodule

// File: tb/tb_mem_sched.sv
// Directed bench for mem_sched with a byte RAM model of one-cycle read latency.
module tb_mem_sched;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, flush_in;
  logic        if_req_in, ld_req_in, st_req_in, ld_signed_in;
  logic [31:0] if_addr_in, ld_addr_in, st_addr_in, st_data_in;
  logic [1:0]  ld_size_in, st_size_in;
  logic        if_ack_out, ld_ack_out, st_ack_out;
  logic [31:0] if_data_out, ld_data_out;
  logic [7:0]  ram_rdata_in, ram_wdata_out;
  logic [31:0] ram_addr_out;
  logic        ram_rw_out, busy_out;

  logic [7:0]  mem [0:8191];
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk_in = ~clk_in;

  mem_sched #(.ADDR_W(32), .STARVE_LIM(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .if_req_in(if_req_in), .if_addr_in(if_addr_in), .if_ack_out(if_ack_out), .if_data_out(if_data_out),
    .ld_req_in(ld_req_in), .ld_addr_in(ld_addr_in), .ld_size_in(ld_size_in), .ld_signed_in(ld_signed_in),
    .ld_ack_out(ld_ack_out), .ld_data_out(ld_data_out),
    .st_req_in(st_req_in), .st_addr_in(st_addr_in), .st_size_in(st_size_in), .st_data_in(st_data_in),
    .st_ack_out(st_ack_out), .ram_rdata_in(ram_rdata_in), .ram_addr_out(ram_addr_out),
    .ram_wdata_out(ram_wdata_out), .ram_rw_out(ram_rw_out), .busy_out(busy_out)
  );

  // RAM model; fixed read contents are loaded while reset is held.
  always @(posedge clk_in) begin
    if (!rst_in) begin
      mem[13'h0100] <= 8'h13; mem[13'h0101] <= 8'h05;
      mem[13'h0102] <= 8'h00; mem[13'h0103] <= 8'h00;
      mem[13'h0200] <= 8'h80;
      mem[13'h0210] <= 8'h34; mem[13'h0211] <= 8'h92;
      mem[13'h1FFF] <= 8'h7F; mem[13'h0000] <= 8'h01;
      ram_rdata_in  <= 8'h00;
    end else begin
      if (ram_rw_out) mem[ram_addr_out[12:0]] <= ram_wdata_out;
      ram_rdata_in <= mem[ram_addr_out[12:0]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // sel: 0=IF 1=LD 2=ST. Returns the number of falling edges until that ack.
  task automatic wait_ack(input string tag, input int sel, input int budget, output int n);
    logic hit;
    n = 0;
    hit = 1'b0;
    while (!hit && n < budget) begin
      @(negedge clk_in);
      n++;
      case (sel)
        0:       hit = if_ack_out;
        1:       hit = ld_ack_out;
        default: hit = st_ack_out;
      endcase
    end
    if (!hit) chk({tag, "_timeout"}, 32'd0, 32'd1);
    else chk({tag, "_acks"}, {29'd0, if_ack_out, ld_ack_out, st_ack_out}, 32'd1 << (2 - sel));
  endtask

  task automatic drop_reqs();
    if_req_in = 1'b0; ld_req_in = 1'b0; st_req_in = 1'b0;
  endtask

  logic [31:0] t_addr [6] = '{32'h200, 32'h210, 32'h210, 32'hFFFFFFFF, 32'h100, 32'h100};
  logic [1:0]  t_size [6] = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd3, 2'd2};
  logic        t_sgn  [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  logic [31:0] t_exp  [6] = '{32'h00000080, 32'hFFFF9234, 32'h00009234, 32'h0000017F, 32'h00000513, 32'h00000513};
  int          t_lat  [6] = '{3, 4, 4, 4, 6, 6};

  initial begin
    int n, n_ld;
    logic [31:0] w;
    rst_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0;
    drop_reqs();
    if_addr_in = 32'd0; ld_addr_in = 32'd0; st_addr_in = 32'd0; st_data_in = 32'd0;
    ld_size_in = 2'd0; ld_signed_in = 1'b0; st_size_in = 2'd0;
    repeat (2) @(negedge clk_in);
    chk("rst_busy", busy_out, 32'd0);
    chk("rst_rw", ram_rw_out, 32'd0);
    chk("rst_addr", ram_addr_out, 32'd0);
    chk("rst_acks", {if_ack_out, ld_ack_out, st_ack_out}, 32'd0);
    rst_in = 1'b1;
    @(negedge clk_in);

    // 1: lone fetch
    if_req_in = 1'b1; if_addr_in = 32'h100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk("t1_addr", ram_addr_out, 32'h100 + k);
      chk("t1_rw", ram_rw_out, 32'd0);
    end
    @(negedge clk_in);
    chk("t1_c5_ack", if_ack_out, 32'd0);
    chk("t1_c5_addr", ram_addr_out, 32'd0);
    @(negedge clk_in);
    chk("t1_ack", if_ack_out, 32'd1);
    chk("t1_data", if_data_out, 32'h00000513);
    if_req_in = 1'b0;
    @(negedge clk_in);
    chk("t1_ack_drop", if_ack_out, 32'd0);
    chk("t1_busy", busy_out, 32'd0);

    // 2: ST, LD, IF requested together
    st_req_in = 1'b1; st_addr_in = 32'h1000; st_size_in = 2'd2; st_data_in = 32'hDEADBEEF;
    ld_req_in = 1'b1; ld_addr_in = 32'h200; ld_size_in = 2'd0; ld_signed_in = 1'b1;
    if_req_in = 1'b1; if_addr_in = 32'h100;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_in);
      chk("t2_waddr", ram_addr_out, 32'h1000 + k);
      chk("t2_rw", ram_rw_out, 32'd1);
      chk("t2_wdata", ram_wdata_out, (32'hDEADBEEF >> (8 * k)) & 32'hFF);
    end
    @(negedge clk_in);
    chk("t2_st_ack", {if_ack_out, ld_ack_out, st_ack_out}, 32'd1);
    chk("t2_rw_off", ram_rw_out, 32'd0);
    st_req_in = 1'b0;
    wait_ack("t2_ld", 1, 20, n);
    chk("t2_ld_lat", n, 32'd4);
    chk("t2_lb", ld_data_out, 32'hFFFFFF80);
    ld_req_in = 1'b0;
    wait_ack("t2_if", 0, 20, n);
    chk("t2_if_lat", n, 32'd7);
    chk("t2_if_data", if_data_out, 32'h00000513);
    chk("t2_mem", {mem[13'h1003], mem[13'h1002], mem[13'h1001], mem[13'h1000]}, 32'hDEADBEEF);
    drop_reqs();
    @(negedge clk_in);

    // 3: load sizes, extension, address wrap, size code 3
    for (int i = 0; i < 6; i++) begin
      ld_req_in = 1'b1; ld_addr_in = t_addr[i]; ld_size_in = t_size[i]; ld_signed_in = t_sgn[i];
      wait_ack("t3_ld", 1, 20, n);
      chk("t3_lat", n, t_lat[i]);
      chk("t3_data", ld_data_out, t_exp[i]);
      drop_reqs();
      @(negedge clk_in);
    end

    // 4a: flush while fetch drives byte 2
    if_req_in = 1'b1; if_addr_in = 32'h100;
    repeat (3) @(negedge clk_in);
    chk("t4_addr_b2", ram_addr_out, 32'h102);
    flush_in = 1'b1; if_req_in = 1'b0;
    @(negedge clk_in);
    chk("t4_busy", busy_out, 32'd0);
    chk("t4_rw", ram_rw_out, 32'd0);
    chk("t4_addr", ram_addr_out, 32'd0);
    flush_in = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk("t4_no_ack", if_ack_out, 32'd0);
      @(negedge clk_in);
    end

    // 4b: flush during store byte 1 is ignored
    st_req_in = 1'b1; st_addr_in = 32'h1100; st_size_in = 2'd2; st_data_in = 32'h11223344;
    repeat (2) @(negedge clk_in);
    chk("t4_st_b1", ram_addr_out, 32'h1101);
    flush_in = 1'b1;
    @(negedge clk_in);
    flush_in = 1'b0;
    chk("t4_st_rw", ram_rw_out, 32'd1);
    wait_ack("t4_st", 2, 20, n);
    chk("t4_st_lat", n, 32'd2);
    chk("t4_st_mem", {mem[13'h1103], mem[13'h1102], mem[13'h1101], mem[13'h1100]}, 32'h11223344);
    drop_reqs();
    @(negedge clk_in);

    // 5: starvation guard with STARVE_LIM=4
    ld_req_in = 1'b1; ld_addr_in = 32'h200; ld_size_in = 2'd0; ld_signed_in = 1'b0;
    if_req_in = 1'b1; if_addr_in = 32'h100;
    n = 0; n_ld = 0;
    while (!if_ack_out && n < 40) begin
      @(negedge clk_in);
      n++;
      if (ld_ack_out) n_ld++;
      if (n == 16) chk("t5_cnt_sat", dut.r_starve_cnt, 32'd4);
    end
    chk("t5_if_lat", n, 32'd22);
    chk("t5_ld_cnt", n_ld, 32'd4);
    chk("t5_cnt_clr", dut.r_starve_cnt, 32'd0);
    chk("t5_if_data", if_data_out, 32'h00000513);
    drop_reqs();
    @(negedge clk_in);

    // 6a: three stall cycles in the middle of a fetch
    if_req_in = 1'b1; if_addr_in = 32'h100;
    repeat (2) @(negedge clk_in);
    rdy_in = 1'b0;
    @(negedge clk_in);
    chk("t6_hold_addr", ram_addr_out, 32'h101);
    repeat (2) @(negedge clk_in);
    rdy_in = 1'b1;
    wait_ack("t6_if", 0, 20, n);
    chk("t6_if_lat", n, 32'd4);
    chk("t6_if_data", if_data_out, 32'h00000513);
    drop_reqs();
    @(negedge clk_in);

    // 6b: asynchronous reset during store byte 2
    st_req_in = 1'b1; st_addr_in = 32'h1200; st_size_in = 2'd2; st_data_in = 32'hAABBCCDD;
    repeat (3) @(negedge clk_in);
    chk("t6_wr_b2", ram_rw_out, 32'd1);
    #1 rst_in = 1'b0;
    #1;
    chk("t6_rst_rw", ram_rw_out, 32'd0);
    chk("t6_rst_acks", {if_ack_out, ld_ack_out, st_ack_out}, 32'd0);
    chk("t6_rst_busy", busy_out, 32'd0);
    chk("t6_rst_addr", ram_addr_out, 32'd0);
    drop_reqs();
    @(negedge clk_in);
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    chk("t6_post_busy", busy_out, 32'd0);
    chk("t6_post_rw", ram_rw_out, 32'd0);
    chk("t6_post_acks", {if_ack_out, ld_ack_out, st_ack_out}, 32'd0);
    chk("t6_post_addr", ram_addr_out, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
